temp_ascii_tx: RTL and testbench
================================

TEMP_ASCII_TX -- requirements
Module: temp_ascii_tx

Interface
REQ-001 SHALL have parameter: SEND_LF, default 1, 1 = message ends CR LF (8 bytes), 0 = message ends CR only (7 bytes).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: temp_valid  input  1  one-cycle pulse, temp_data valid.
REQ-005 SHALL have port: temp_data  input  13  signed two's complement, LSB = 0.0625 degC.
REQ-006 SHALL have port: tx_done_tick  input  1  one-cycle pulse from UART transmitter, byte fully sent.
REQ-007 SHALL have port: tx_start_n  output  1  active-low byte-start strobe to UART transmitter.
REQ-008 SHALL have port: data_byte  output  8  ASCII byte to UART transmitter.
REQ-009 SHALL have port: busy  output  1  high from capture until message complete.
REQ-010 SHALL have port: msg_done_tick  output  1  one-cycle pulse, last byte acknowledged.
REQ-011 SHALL have port: drop_tick  output  1  one-cycle pulse, temp_valid ignored.

Function
REQ-012 SHALL implement states IDLE, CONVERT, SEND, WAIT_DONE.
REQ-013 IDLE: temp_valid=1 SHALL capture temp_data, set busy next cycle, go to CONVERT; otherwise stay.
REQ-014 temp_valid in any state other than IDLE (including the WAIT_DONE cycle receiving the final tx_done_tick) SHALL be discarded and SHALL pulse drop_tick for one cycle.
REQ-015 CONVERT: sign = temp_data[12]; mag = 13-bit absolute value (0x1000 gives mag 4096); int = mag[12:4] (0..256), frac = mag[3:0].
REQ-016 CONVERT SHALL derive hundreds, tens, units digits of int by sequential subtract-100 then subtract-10, at most one subtraction per cycle; SHALL complete in at most 16 cycles.
REQ-017 Fraction digit SHALL be (frac*10)>>4, truncated (0..9).
REQ-018 Message, byte 0 first: sign ('+'=0x2B if sign=0, '-'=0x2D if sign=1, including -0.0625), hundreds, tens, units (0x30+digit, leading zeros kept), '.'=0x2E, fraction digit, 0x0D, then 0x0A if SEND_LF=1.
REQ-019 No byte SHALL be issued before conversion completes; CONVERT then goes to SEND with byte index 0.
REQ-020 SEND: registered tx_start_n SHALL be low for exactly one cycle with data_byte = message[index] in the same cycle; next state WAIT_DONE.
REQ-021 data_byte SHALL hold stable from the tx_start_n low cycle until tx_done_tick for that byte.
REQ-022 tx_start_n SHALL stay high in every state except the single SEND cycle; never low for two consecutive cycles.
REQ-023 WAIT_DONE: tx_done_tick with index < last SHALL increment index, go to SEND; with index = last SHALL go to IDLE, pulse msg_done_tick, clear busy next cycle.
REQ-024 tx_done_tick outside WAIT_DONE SHALL be ignored.
REQ-025 Inter-byte gap SHALL be exactly 1 cycle: tx_done_tick at cycle N, tx_start_n low at cycle N+1.

Reset
REQ-026 reset SHALL force IDLE, tx_start_n=1, data_byte=0x00, busy=0, msg_done_tick=0, drop_tick=0, index=0, digits=0.
REQ-027 reset mid-message SHALL abort with no further tx_start_n pulses; a later temp_valid SHALL start a fresh message from byte 0.

Verification
REQ-028 temp_data=0x0198 (+25.5) -> bytes 2B 30 32 35 2E 35 0D 0A, 8 tx_start_n pulses, one msg_done_tick after 8th tx_done_tick.
REQ-029 temp_data=0x1C90 (-55.0) -> 2D 30 35 35 2E 30 0D 0A; temp_data=0x1FFF -> 2D 30 30 30 2E 30 0D 0A.
REQ-030 Extremes: 0x0FFF -> 2B 32 35 35 2E 39 0D 0A; 0x1000 -> 2D 32 35 36 2E 30 0D 0A.
REQ-031 temp_valid during WAIT_DONE of byte 3 -> drop_tick pulse, message unchanged, no second message.
REQ-032 reset asserted while in WAIT_DONE of byte 4 -> all outputs at reset values next cycle, no tx_start_n until next temp_valid.
REQ-033 SEND_LF=0, temp_data=0x0000 -> 2B 30 30 30 2E 30 0D, 7 pulses, msg_done_tick after 7th tx_done_tick.

Source files
------------

// File: rtl/temp_ascii_tx.sv
// Converts a captured 13-bit signed temperature (1/16 degC LSB) into a fixed-format
// ASCII line "+ddd.d\r[\n]" and feeds it byte by byte to a UART transmitter handshake.
module temp_ascii_tx #(
  parameter int SEND_LF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        temp_valid,
  input  logic [12:0] temp_data,
  input  logic        tx_done_tick,
  output logic        tx_start_n,
  output logic [7:0]  data_byte,
  output logic        busy,
  output logic        msg_done_tick,
  output logic        drop_tick
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CONVERT   = 2'd1,
    S_SEND      = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = (SEND_LF != 0) ? 3'd7 : 3'd6;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        sign_q, sign_d;
  logic [8:0]  rem_q, rem_d;
  logic [3:0]  frac_q, frac_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic        phase_q, phase_d;
  logic        tx_start_n_q, tx_start_n_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic        busy_q, busy_d;
  logic        msg_done_q, msg_done_d;
  logic        drop_q, drop_d;
  logic [12:0] mag_s;
  logic [3:0]  frac_digit_s;

  // Truncated first decimal of a 1/16 fraction: (f*10)>>4.
  function automatic logic [3:0] frac_digit(input logic [3:0] f);
    logic [7:0] prod;
    prod = {4'd0, f} * 8'd10;
    return 4'(prod >> 8'd4);
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] i, input logic s,
                                          input logic [3:0] h, input logic [3:0] t,
                                          input logic [3:0] u, input logic [3:0] f);
    logic [7:0] b;
    case (i)
      3'd0:    b = s ? 8'h2D : 8'h2B;
      3'd1:    b = 8'h30 + {4'd0, h};
      3'd2:    b = 8'h30 + {4'd0, t};
      3'd3:    b = 8'h30 + {4'd0, u};
      3'd4:    b = 8'h2E;
      3'd5:    b = 8'h30 + {4'd0, f};
      3'd6:    b = 8'h0D;
      3'd7:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Magnitude is 13 bits wide so the most negative code (0x1000) maps to 4096.
  assign mag_s        = temp_data[12] ? (~temp_data + 13'd1) : temp_data;
  assign frac_digit_s = frac_digit(frac_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sign_d       = sign_q;
    rem_d        = rem_q;
    frac_d       = frac_q;
    hund_d       = hund_q;
    tens_d       = tens_q;
    units_d      = units_q;
    phase_d      = phase_q;
    tx_start_n_d = 1'b1;
    data_byte_d  = data_byte_q;
    busy_d       = busy_q;
    msg_done_d   = 1'b0;
    if (temp_valid && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (temp_valid) begin
          sign_d  = temp_data[12];
          rem_d   = mag_s[12:4];
          frac_d  = mag_s[3:0];
          hund_d  = 4'd0;
          tens_d  = 4'd0;
          units_d = 4'd0;
          phase_d = 1'b0;
          idx_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        // One subtraction per cycle: hundreds first, then tens, remainder is units.
        if (!phase_q) begin
          if (rem_q >= 9'd100) begin
            rem_d  = rem_q - 9'd100;
            hund_d = hund_q + 4'd1;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          if (rem_q >= 9'd10) begin
            rem_d  = rem_q - 9'd10;
            tens_d = tens_q + 4'd1;
          end else begin
            units_d      = 4'(rem_q);
            idx_d        = 3'd0;
            state_d      = S_SEND;
            tx_start_n_d = 1'b0;
            data_byte_d  = msg_byte(3'd0, sign_q, hund_q, tens_q, 4'd0, frac_digit_s);
          end
        end
      end
      S_SEND: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done_tick) begin
          if (idx_q == LAST_IDX) begin
            state_d    = S_IDLE;
            msg_done_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            idx_d        = idx_q + 3'd1;
            state_d      = S_SEND;
            tx_start_n_d = 1'b0;
            data_byte_d  = msg_byte(idx_q + 3'd1, sign_q, hund_q, tens_q, units_q,
                                   frac_digit_s);
          end
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      sign_q       <= 1'b0;
      rem_q        <= 9'd0;
      frac_q       <= 4'd0;
      hund_q       <= 4'd0;
      tens_q       <= 4'd0;
      units_q      <= 4'd0;
      phase_q      <= 1'b0;
      tx_start_n_q <= 1'b1;
      data_byte_q  <= 8'h00;
      busy_q       <= 1'b0;
      msg_done_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sign_q       <= sign_d;
      rem_q        <= rem_d;
      frac_q       <= frac_d;
      hund_q       <= hund_d;
      tens_q       <= tens_d;
      units_q      <= units_d;
      phase_q      <= phase_d;
      tx_start_n_q <= tx_start_n_d;
      data_byte_q  <= data_byte_d;
      busy_q       <= busy_d;
      msg_done_q   <= msg_done_d;
      drop_q       <= drop_d;
    end
  end

  assign tx_start_n    = tx_start_n_q;
  assign data_byte     = data_byte_q;
  assign busy          = busy_q;
  assign msg_done_tick = msg_done_q;
  assign drop_tick     = drop_q;

endmodule

// File: tb/tb_temp_ascii_tx.sv
// Directed bench for temp_ascii_tx: one CR LF instance and one CR-only instance,
// with a scripted UART responder and hand-computed byte streams.
module tb_temp_ascii_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] temp_data = 13'd0;
  logic        a_valid = 1'b0, a_tick = 1'b0;
  logic        b_valid = 1'b0, b_tick = 1'b0;
  logic        a_start_n, a_busy, a_done, a_drop;
  logic        b_start_n, b_busy, b_done, b_drop;
  logic [7:0]  a_byte, b_byte;
  logic        sel = 1'b0;
  logic        start_o, busy_o, done_o, drop_o;
  logic [7:0]  data_o;
  int          vectors = 0;
  int          miscompares = 0;

  temp_ascii_tx #(.SEND_LF(1)) dut_a (
    .clk(clk), .reset(reset), .temp_valid(a_valid), .temp_data(temp_data),
    .tx_done_tick(a_tick), .tx_start_n(a_start_n), .data_byte(a_byte),
    .busy(a_busy), .msg_done_tick(a_done), .drop_tick(a_drop)
  );

  temp_ascii_tx #(.SEND_LF(0)) dut_b (
    .clk(clk), .reset(reset), .temp_valid(b_valid), .temp_data(temp_data),
    .tx_done_tick(b_tick), .tx_start_n(b_start_n), .data_byte(b_byte),
    .busy(b_busy), .msg_done_tick(b_done), .drop_tick(b_drop)
  );

  always #5 clk = ~clk;

  assign start_o = sel ? b_start_n : a_start_n;
  assign data_o  = sel ? b_byte    : a_byte;
  assign busy_o  = sel ? b_busy    : a_busy;
  assign done_o  = sel ? b_done    : a_done;
  assign drop_o  = sel ? b_drop    : a_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel) b_valid = v;
    else     a_valid = v;
  endtask

  task automatic drive_tick(input logic v);
    if (sel) b_tick = v;
    else     a_tick = v;
  endtask

  // Runs one message; drop_at/abort_at pick the byte after which a stray
  // temp_valid or a reset is injected (-1 = none).
  task automatic run_msg(input logic [12:0] td, input logic [63:0] exp, input int n,
                         input int drop_at, input int abort_at);
    int pulses;
    int cnt;
    int lows;
    logic [7:0] eb;
    pulses = 0;
    temp_data = td;
    drive_valid(1'b1);
    @(negedge clk);
    drive_valid(1'b0);
    chk("busy_set", busy_o, 1);
    chk("start_idle_high", start_o, 1);
    for (int i = 0; i < n; i++) begin
      eb = exp[63 - 8*i -: 8];
      cnt = 0;
      while (start_o !== 1'b0 && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 40) begin
        chk("start_timeout", start_o, 0);
        return;
      end
      pulses++;
      chk("byte", data_o, eb);
      @(negedge clk);
      chk("start_one_cycle", start_o, 1);
      chk("byte_hold", data_o, eb);
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_start_n", start_o, 1);
        chk("rst_data", data_o, 8'h00);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_drop", drop_o, 0);
        lows = 0;
        repeat (30) begin
          @(negedge clk);
          if (start_o !== 1'b1) lows++;
        end
        chk("abort_quiet", lows, 0);
        return;
      end
      if (i == drop_at) begin
        drive_valid(1'b1);
        @(negedge clk);
        drive_valid(1'b0);
        chk("drop_tick", drop_o, 1);
      end else begin
        @(negedge clk);
      end
      chk("byte_hold2", data_o, eb);
      drive_tick(1'b1);
      @(negedge clk);
      drive_tick(1'b0);
      if (i == drop_at) chk("drop_one_cycle", drop_o, 0);
      if (i < n - 1) begin
        chk("gap_start", start_o, 0);
      end else begin
        chk("msg_done", done_o, 1);
        chk("busy_clear", busy_o, 0);
        chk("last_start_high", start_o, 1);
      end
    end
    chk("pulse_count", pulses, n);
    @(negedge clk);
    chk("msg_done_once", done_o, 0);
    lows = 0;
    repeat (15) begin
      @(negedge clk);
      if (start_o !== 1'b1) lows++;
    end
    chk("no_second_msg", lows, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_start_n", a_start_n, 1);
    chk("reset_data", a_byte, 8'h00);
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);
    chk("reset_drop", a_drop, 0);
    chk("reset_b_start_n", b_start_n, 1);

    // Stray tx_done_tick while idle must do nothing.
    a_tick = 1'b1;
    @(negedge clk);
    a_tick = 1'b0;
    @(negedge clk);
    chk("idle_tick_start", a_start_n, 1);
    chk("idle_tick_busy", a_busy, 0);

    sel = 1'b0;
    run_msg(13'h0198, 64'h2B3032352E350D0A, 8, -1, -1);
    run_msg(13'h1C90, 64'h2D3035352E300D0A, 8, -1, -1);
    run_msg(13'h1FFF, 64'h2D3030302E300D0A, 8, -1, -1);
    run_msg(13'h0FFF, 64'h2B3235352E390D0A, 8, -1, -1);
    run_msg(13'h1000, 64'h2D3235362E300D0A, 8, -1, -1);
    run_msg(13'h0198, 64'h2B3032352E350D0A, 8, 3, -1);
    run_msg(13'h1C90, 64'h2D3035352E300D0A, 8, -1, 4);
    run_msg(13'h0198, 64'h2B3032352E350D0A, 8, -1, -1);

    sel = 1'b1;
    run_msg(13'h0000, 64'h2B3030302E300D00, 7, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
